// File: rtl/gx4000_sfx_pkg.sv
`default_nettype none
// ============================================================================
// Package  : gx4000_sfx_pkg
// Brief    : Register map, ctrl bit positions and enums for the SFX mixer.
// Revision : 1.0 - initial release
// ============================================================================
package gx4000_sfx_pkg;

    localparam logic [1:0] PERIOD_LO = 2'd0;
    localparam logic [1:0] CTRL      = 2'd1;
    localparam logic [1:0] VOLUME    = 2'd2;
    localparam logic [1:0] LENGTH    = 2'd3;

    localparam int CTRL_EN_BIT      = 7;
    localparam int CTRL_ONESHOT_BIT = 6;
    localparam int CTRL_PAN_MSB     = 5;
    localparam int CTRL_PAN_LSB     = 4;
    localparam int REG_BYTES        = 4;

    typedef enum logic [1:0] {
        PAN_BOTH  = 2'b00,
        PAN_LEFT  = 2'b01,
        PAN_RIGHT = 2'b10,
        PAN_MUTE  = 2'b11
    } pan_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } voice_state_e;

endpackage
`default_nettype wire

// File: rtl/gx4000_sfx_voice.sv
`default_nettype none
// ============================================================================
// Module   : gx4000_sfx_voice
// Brief    : One square-wave voice: registers, period counter, one-shot logic.
// Revision : 1.0 - initial release
// ============================================================================
module gx4000_sfx_voice
    import gx4000_sfx_pkg::*;
#(
    parameter int OUT_W    = 8,
    parameter int VOL_W    = 4,
    parameter int PERIOD_W = 12
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             plus_mode,
    input  logic             wr_en,
    input  logic [1:0]       wr_offset,
    input  logic [7:0]       wr_data,
    input  logic             sample_tick,
    output logic [OUT_W-1:0] contrib_l,
    output logic [OUT_W-1:0] contrib_r,
    output logic             active,
    output logic             done
);

    voice_state_e        r_state,     w_state_nxt;
    logic [PERIOD_W-1:0] r_period,    w_period_nxt;
    logic                r_oneshot,   w_oneshot_nxt;
    pan_e                r_pan,       w_pan_nxt;
    logic [VOL_W-1:0]    r_volume,    w_volume_nxt;
    logic [7:0]          r_length,    w_length_nxt;
    logic [PERIOD_W-1:0] r_counter,   w_counter_nxt;
    logic                r_phase,     w_phase_nxt;
    logic [7:0]          r_remaining, w_remaining_nxt;
    logic                r_done,      w_done_nxt;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_period    <= '0;
            r_oneshot   <= 1'b0;
            r_pan       <= PAN_BOTH;
            r_volume    <= '0;
            r_length    <= '0;
            r_counter   <= '0;
            r_phase     <= 1'b0;
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_period    <= w_period_nxt;
            r_oneshot   <= w_oneshot_nxt;
            r_pan       <= w_pan_nxt;
            r_volume    <= w_volume_nxt;
            r_length    <= w_length_nxt;
            r_counter   <= w_counter_nxt;
            r_phase     <= w_phase_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_period_nxt    = r_period;
        w_oneshot_nxt   = r_oneshot;
        w_pan_nxt       = r_pan;
        w_volume_nxt    = r_volume;
        w_length_nxt    = r_length;
        w_counter_nxt   = r_counter;
        w_phase_nxt     = r_phase;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;

        if (!plus_mode) begin
            w_state_nxt = IDLE;
            w_phase_nxt = 1'b0;
        end else begin
            if (wr_en && wr_offset == PERIOD_LO) w_period_nxt[7:0] = wr_data;
            if (wr_en && wr_offset == VOLUME)    w_volume_nxt      = wr_data[VOL_W-1:0];
            if (wr_en && wr_offset == LENGTH)    w_length_nxt      = wr_data;

            // A ctrl write overrides any tick expiry in the same cycle.
            if (wr_en && wr_offset == CTRL) begin
                w_period_nxt[PERIOD_W-1:8] = wr_data[PERIOD_W-9:0];
                w_oneshot_nxt              = wr_data[CTRL_ONESHOT_BIT];
                w_pan_nxt                  = pan_e'(wr_data[CTRL_PAN_MSB:CTRL_PAN_LSB]);
                w_phase_nxt                = 1'b0;
                if (wr_data[CTRL_EN_BIT]) begin
                    w_state_nxt     = RUN;
                    w_counter_nxt   = w_period_nxt;
                    w_remaining_nxt = r_length;
                end else begin
                    w_state_nxt = IDLE;
                end
            end else if (r_state == RUN && sample_tick && r_period != '0) begin
                // counter == 0 only arises after enabling with period 0; treat as expiry.
                if (r_counter <= PERIOD_W'(1)) begin
                    w_counter_nxt = r_period;
                    w_phase_nxt   = ~r_phase;
                    if (r_oneshot && r_remaining != 8'd0) begin
                        w_remaining_nxt = r_remaining - 8'd1;
                        if (r_remaining == 8'd1) begin
                            w_state_nxt = IDLE;
                            w_phase_nxt = 1'b0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end else begin
                    w_counter_nxt = r_counter - PERIOD_W'(1);
                end
            end
        end
    end

    logic             w_sounding;
    logic [OUT_W-1:0] w_level;

    assign w_sounding = plus_mode && (r_state == RUN) && r_phase;
    assign w_level    = OUT_W'(r_volume) << (OUT_W - VOL_W);
    assign contrib_l  = (w_sounding && (r_pan == PAN_BOTH || r_pan == PAN_LEFT))  ? w_level : '0;
    assign contrib_r  = (w_sounding && (r_pan == PAN_BOTH || r_pan == PAN_RIGHT)) ? w_level : '0;
    assign active     = (r_state == RUN);
    assign done       = r_done;

endmodule
`default_nettype wire

// File: rtl/gx4000_sfx_mixer.sv
`default_nettype none
// ============================================================================
// Module   : gx4000_sfx_mixer
// Brief    : Plus-mode SFX voices, register decode and saturating stereo mix.
// Revision : 1.0 - initial release
// ============================================================================
module gx4000_sfx_mixer
    import gx4000_sfx_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          OUT_W     = 8,
    parameter int          VOL_W     = 4,
    parameter int          PERIOD_W  = 12,
    parameter logic [15:0] BASE_ADDR = 16'hBCE0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              plus_mode,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_data,
    input  logic              cpu_wr,
    input  logic              sample_tick,
    input  logic [OUT_W-1:0]  cpc_audio_l,
    input  logic [OUT_W-1:0]  cpc_audio_r,
    output logic [OUT_W-1:0]  audio_l,
    output logic [OUT_W-1:0]  audio_r,
    output logic [7:0]        audio_status,
    output logic [NUM_CH-1:0] sfx_done
);

    localparam int c_ACC_W = OUT_W + $clog2(NUM_CH + 1);
    localparam int c_SPAN  = REG_BYTES * NUM_CH;

    logic [15:0]       w_rel;
    logic              w_in_range;
    logic              w_wr_ok;
    logic [NUM_CH-1:0] w_wr_en;
    logic [NUM_CH-1:0] w_active;
    logic [OUT_W-1:0]  w_contrib_l [NUM_CH];
    logic [OUT_W-1:0]  w_contrib_r [NUM_CH];

    assign w_rel      = cpu_addr - BASE_ADDR;
    assign w_in_range = (cpu_addr >= BASE_ADDR) && (w_rel < 16'(c_SPAN));
    assign w_wr_ok    = cpu_wr && plus_mode && w_in_range;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_voice
            assign w_wr_en[g] = w_wr_ok && (w_rel[15:2] == 14'(g));

            gx4000_sfx_voice #(
                .OUT_W    (OUT_W),
                .VOL_W    (VOL_W),
                .PERIOD_W (PERIOD_W)
            ) u_voice (
                .clk_sys     (clk_sys),
                .reset_n     (reset_n),
                .plus_mode   (plus_mode),
                .wr_en       (w_wr_en[g]),
                .wr_offset   (w_rel[1:0]),
                .wr_data     (cpu_data),
                .sample_tick (sample_tick),
                .contrib_l   (w_contrib_l[g]),
                .contrib_r   (w_contrib_r[g]),
                .active      (w_active[g]),
                .done        (sfx_done[g])
            );
        end
    endgenerate

    logic [c_ACC_W-1:0] w_sum_l, w_sum_r;
    logic [OUT_W-1:0]   w_mix_l, w_mix_r;
    logic [7:0]         w_status;

    // The accumulator is wide enough for every voice at full scale, so it never wraps.
    always_comb begin
        w_sum_l  = c_ACC_W'(cpc_audio_l);
        w_sum_r  = c_ACC_W'(cpc_audio_r);
        w_status = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum_l     = w_sum_l + c_ACC_W'(w_contrib_l[i]);
            w_sum_r     = w_sum_r + c_ACC_W'(w_contrib_r[i]);
            w_status[i] = w_active[i];
        end
        w_mix_l = (|w_sum_l[c_ACC_W-1:OUT_W]) ? '1 : w_sum_l[OUT_W-1:0];
        w_mix_r = (|w_sum_r[c_ACC_W-1:OUT_W]) ? '1 : w_sum_r[OUT_W-1:0];
    end

    logic [OUT_W-1:0] r_audio_l, r_audio_r;
    logic [7:0]       r_status;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_audio_l <= '0;
            r_audio_r <= '0;
            r_status  <= '0;
        end else begin
            r_audio_l <= w_mix_l;
            r_audio_r <= w_mix_r;
            r_status  <= w_status;
        end
    end

    assign audio_l      = r_audio_l;
    assign audio_r      = r_audio_r;
    assign audio_status = r_status;

endmodule
`default_nettype wire
